// File: rtl/ev_player_pkg.sv
// Shared types and entry-word packing for the event stimulus player.
// Entry layout, LSB first: gap | mask | channel data (channel 0 lowest).
package ev_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Upper bound for any legal NUM_IN/DATA_W/GAP_W combination.
  localparam int MAX_ENTRY_W = 2048;
  typedef logic [MAX_ENTRY_W-1:0] entry_word_t;

  function automatic int entry_w(int gap_w, int num_in, int data_w);
    return gap_w + num_in + num_in * data_w;
  endfunction

  function automatic entry_word_t pack_entry(int gap_w, int num_in, entry_word_t gap,
                                             entry_word_t mask, entry_word_t data);
    return gap | (mask << gap_w) | (data << (gap_w + num_in));
  endfunction

  function automatic entry_word_t unpack_field(entry_word_t word, int lsb, int width);
    entry_word_t keep;
    keep = '1;
    keep = ~(keep << width);
    return (word >> lsb) & keep;
  endfunction

endpackage

// File: rtl/ev_player_sched_mem.sv
// Schedule storage: DEPTH x WIDTH register array, one write port and one
// asynchronous read port. Contents are deliberately not reset.
module ev_sched_mem #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/event_stimulus_player.sv
// Replays a loaded schedule of timestamped events into monitor input ports.
// Optional feature macro: EV_PLAYER_LOOP_EN (adds the loop input).
module event_stimulus_player
  import ev_player_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 32,
  parameter int GAP_W   = 16,
  parameter int STALL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       ld_we,
  input  logic [$clog2(DEPTH)-1:0]   ld_addr,
  input  logic [GAP_W-1:0]           ld_gap,
  input  logic [NUM_IN-1:0]          ld_mask,
  input  logic [NUM_IN*DATA_W-1:0]   ld_data,
  input  logic [$clog2(DEPTH):0]     ev_count,
  input  logic                       start,
  input  logic                       ready,
`ifdef EV_PLAYER_LOOP_EN
  input  logic                       loop,
`endif
  output logic [NUM_IN*DATA_W-1:0]   input_data,
  output logic [NUM_IN-1:0]          new_input,
  output logic                       busy,
  output logic                       done,
  output logic [STALL_W-1:0]         stall_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(GAP_W, NUM_IN, DATA_W);

  state_e                   state_q;
  logic [AW-1:0]            idx_q;
  logic [GAP_W-1:0]         cnt_q;
  logic                     reload_q;
  logic [AW:0]              evc_q;
  logic [STALL_W-1:0]       stall_q;
  logic [NUM_IN-1:0]        new_q;
  logic [NUM_IN*DATA_W-1:0] data_q;
  logic                     done_q;

  logic [ENTRY_W-1:0]       wr_word, rd_word;
  logic [GAP_W-1:0]         rd_gap, cnt_eff;
  logic [NUM_IN-1:0]        rd_mask;
  logic [NUM_IN*DATA_W-1:0] rd_data, rd_data_m;
  logic                     mem_we, last, loop_on;

`ifdef EV_PLAYER_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  assign mem_we  = ld_we && en && (state_q != ST_WAIT);
  assign wr_word = ENTRY_W'(pack_entry(GAP_W, NUM_IN, entry_word_t'(ld_gap),
                                       entry_word_t'(ld_mask), entry_word_t'(ld_data)));

  ev_sched_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (ld_addr),
    .wdata_i (wr_word),
    .raddr_i (idx_q),
    .rdata_o (rd_word)
  );

  assign rd_gap  = GAP_W'(unpack_field(entry_word_t'(rd_word), 0, GAP_W));
  assign rd_mask = NUM_IN'(unpack_field(entry_word_t'(rd_word), GAP_W, NUM_IN));
  assign rd_data = (NUM_IN*DATA_W)'(unpack_field(entry_word_t'(rd_word), GAP_W + NUM_IN,
                                                 NUM_IN * DATA_W));

  always_comb begin
    rd_data_m = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      if (rd_mask[c]) rd_data_m[c*DATA_W +: DATA_W] = rd_data[c*DATA_W +: DATA_W];
    end
  end

  // A single read port serves both the firing entry and the next gap: after a
  // fire (or start) the gap is taken straight from memory on the following cycle.
  assign cnt_eff = reload_q ? rd_gap : cnt_q;
  assign last    = (({1'b0, idx_q} + (AW+1)'(1)) == evc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      reload_q <= 1'b0;
      evc_q    <= '0;
      stall_q  <= '0;
      new_q    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      new_q  <= '0;
      data_q <= '0;
      if (en) begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              if (ev_count == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q  <= ST_WAIT;
                evc_q    <= ev_count;
                idx_q    <= '0;
                reload_q <= 1'b1;
                stall_q  <= '0;
                done_q   <= 1'b0;
              end
            end
          end
          ST_WAIT: begin
            if (cnt_eff != '0) begin
              cnt_q    <= cnt_eff - GAP_W'(1);
              reload_q <= 1'b0;
            end else if (ready) begin
              new_q    <= rd_mask;
              data_q   <= rd_data_m;
              cnt_q    <= '0;
              reload_q <= 1'b1;
              if (last) begin
                idx_q <= '0;
                if (!loop_on) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end
              end else begin
                idx_q <= idx_q + AW'(1);
              end
            end else begin
              cnt_q    <= '0;
              reload_q <= 1'b0;
              if (stall_q != '1) stall_q <= stall_q + STALL_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign input_data = data_q;
  assign new_input  = new_q;
  assign busy       = (state_q == ST_WAIT);
  assign done       = done_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_event_stimulus_player.sv
// Bench for event_stimulus_player: schedule table plus a pulse scoreboard.
// Loop coverage is compiled in when EV_PLAYER_LOOP_EN is defined.
module tb_event_stimulus_player;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1, ld_we = 1'b0, start = 1'b0, ready = 1'b1;
  logic [4:0]   ld_addr = '0;
  logic [15:0]  ld_gap = '0;
  logic [3:0]   ld_mask = '0;
  logic [255:0] ld_data = '0;
  logic [5:0]   ev_count = '0;
`ifdef EV_PLAYER_LOOP_EN
  logic         loop = 1'b0;
`endif
  logic [255:0] input_data;
  logic [3:0]   new_input;
  logic         busy, done;
  logic [15:0]  stall_cnt;

  event_stimulus_player #(
    .NUM_IN(4), .DATA_W(64), .DEPTH(32), .GAP_W(16), .STALL_W(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_gap(ld_gap), .ld_mask(ld_mask), .ld_data(ld_data), .ev_count(ev_count),
    .start(start), .ready(ready),
`ifdef EV_PLAYER_LOOP_EN
    .loop(loop),
`endif
    .input_data(input_data), .new_input(new_input), .busy(busy), .done(done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          gap[3];
    logic [3:0]  mask[3];
    logic [63:0] val[3][4];
    int          evc;
    int          st_off, st_len, st_ev;
    int          en_off, en_len, en_ev;
    int          exp_stall;
  } vec_t;

  typedef struct {
    int           cyc;
    logic [3:0]   mask;
    logic [255:0] data;
    bit           last;
  } exp_t;

  vec_t  tbl[6];
  exp_t  sb[$];
  exp_t  me;
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: a pulse must match the scoreboard head, otherwise data must be zero.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (new_input != 4'd0) begin
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse cyc=%0d new_input=%b data=%h", cyc, new_input, input_data);
        end else begin
          me = sb.pop_front();
          if (cyc != me.cyc || new_input != me.mask || input_data != me.data || done != me.last) begin
            fails++;
            $display("FAIL pulse got cyc=%0d mask=%b done=%b data=%h want cyc=%0d mask=%b done=%b data=%h",
                     cyc, new_input, done, input_data, me.cyc, me.mask, me.last, me.data);
          end
        end
      end else if (input_data != '0) begin
        fails++;
        $display("FAIL idle_data cyc=%0d got=%h want=0", cyc, input_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp_v);
    end
  endtask

  function automatic logic [255:0] exp_data(int s, int k);
    logic [255:0] r;
    r = '0;
    for (int ch = 0; ch < 4; ch++)
      if (tbl[s].mask[k][ch]) r[ch*64 +: 64] = tbl[s].val[k][ch];
    return r;
  endfunction

  task automatic load(input int s);
    for (int k = 0; k < 3; k++) begin
      ld_we   = 1'b1;
      ld_addr = 5'(k);
      ld_gap  = 16'(tbl[s].gap[k]);
      ld_mask = tbl[s].mask[k];
      ld_data = {tbl[s].val[k][3], tbl[s].val[k][2], tbl[s].val[k][1], tbl[s].val[k][0]};
      tick();
    end
    ld_we = 1'b0;
  endtask

  task automatic run_sched(input int s, input bit do_load, input bit busy_wr);
    int   st, t;
    exp_t e;
    bit   fin;
    if (do_load) load(s);
    ev_count = 6'(tbl[s].evc);
    start = 1'b1;
    st = cyc;
    t = st + 1;
    for (int k = 0; k < tbl[s].evc; k++) begin
      t += tbl[s].gap[k] + 1;
      e.cyc  = t + ((k >= tbl[s].st_ev) ? tbl[s].st_len : 0)
                 + ((k >= tbl[s].en_ev) ? tbl[s].en_len : 0);
      e.mask = tbl[s].mask[k];
      e.data = exp_data(s, k);
      e.last = (k == tbl[s].evc - 1);
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
    fin = 1'b0;
    for (int c = 1; c < 300 && !fin; c++) begin
      ready = !(c >= tbl[s].st_off && c < tbl[s].st_off + tbl[s].st_len);
      en    = !(c >= tbl[s].en_off && c < tbl[s].en_off + tbl[s].en_len);
      if (busy_wr) begin
        ld_we   = (c == 3);
        ld_addr = '0;
        ld_gap  = 16'd1;
        ld_mask = 4'hF;
        ld_data = '1;
      end
      tick();
      fin = done;
    end
    ready = 1'b1;
    en    = 1'b1;
    ld_we = 1'b0;
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL timeout scenario=%0d done=%b want=1", s, done);
    end
    tick();
    tick();
    check($sformatf("drained_%0d", s), 256'(sb.size()), 256'd0);
    check($sformatf("stall_%0d", s), 256'(stall_cnt), 256'(tbl[s].exp_stall));
    check($sformatf("done_%0d", s), 256'(done), 256'd1);
    check($sformatf("busy_%0d", s), 256'(busy), 256'd0);
    sb.delete();
  endtask

`ifdef EV_PLAYER_LOOP_EN
  task automatic run_loop();
    int   st, t, drop;
    exp_t e;
    bit   fin;
    load(4);
    loop = 1'b1;
    ev_count = 6'd2;
    start = 1'b1;
    st = cyc;
    t = st + 1;
    drop = 0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 2; k++) begin
        t += tbl[4].gap[k] + 1;
        e.cyc  = t;
        e.mask = tbl[4].mask[k];
        e.data = exp_data(4, k);
        e.last = (p == 3 && k == 1);
        sb.push_back(e);
        if (p == 2 && k == 1) drop = t;
      end
    end
    tick();
    start = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (cyc >= drop) loop = 1'b0;
      tick();
      fin = done;
    end
    loop = 1'b0;
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL loop_timeout done=%b want=1", done);
    end
    tick();
    tick();
    check("loop_drained", 256'(sb.size()), 256'd0);
    check("loop_done", 256'(done), 256'd1);
    sb.delete();
  endtask
`endif

  initial begin
    tbl[0].gap  = '{5, 0, 2};
    tbl[0].mask = '{4'b0001, 4'b0011, 4'b1000};
    tbl[0].val  = '{'{64'd1, 64'hAAAA, 64'hBBBB, 64'hCCCC},
                    '{64'd2, 64'd3, 64'hDDDD, 64'hEEEE},
                    '{64'h1111, 64'h2222, 64'h3333, 64'd4}};
    tbl[0].evc = 3;
    tbl[0].st_off = 0; tbl[0].st_len = 0; tbl[0].st_ev = 99;
    tbl[0].en_off = 0; tbl[0].en_len = 0; tbl[0].en_ev = 99;
    tbl[0].exp_stall = 0;
    tbl[1] = tbl[0];
    tbl[1].st_off = 7; tbl[1].st_len = 4; tbl[1].st_ev = 1; tbl[1].exp_stall = 4;
    tbl[2] = tbl[0];
    tbl[2].en_off = 2; tbl[2].en_len = 3; tbl[2].en_ev = 0;
    tbl[3] = tbl[0];
    tbl[3].gap  = '{0, 0, 0};
    tbl[3].mask = '{4'b1111, 4'b0101, 4'b1010};
    tbl[3].val  = '{'{64'hFFFF_FFFF_FFFF_FFFB, 64'h8000_0000_0000_0000, 64'd7, 64'h7FFF_FFFF_FFFF_FFFF},
                    '{64'd10, 64'h55, 64'd12, 64'h66},
                    '{64'h99, 64'd21, 64'h77, 64'hFFFF_FFFF_FFFF_FFFF}};
    tbl[4] = tbl[0];
    tbl[4].gap  = '{3, 1, 7};
    tbl[4].mask = '{4'b0010, 4'b0100, 4'b1001};
    tbl[4].evc  = 2;
    tbl[5] = tbl[0];
    tbl[5].gap  = '{0, 1, 0};
    tbl[5].mask = '{4'b1000, 4'b0001, 4'b0110};
    tbl[5].st_off = 1; tbl[5].st_len = 2; tbl[5].st_ev = 0; tbl[5].exp_stall = 2;

    tick();
    tick();
    rst = 1'b0;
    check("rst_data", input_data, 256'd0);
    check("rst_new", 256'(new_input), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_stall", 256'(stall_cnt), 256'd0);

    for (int s = 0; s < 6; s++) run_sched(s, 1'b1, 1'b0);

    // Load attempted while busy must not corrupt the entry in either pass.
    run_sched(0, 1'b1, 1'b1);
    run_sched(0, 1'b0, 1'b0);

`ifdef EV_PLAYER_LOOP_EN
    run_loop();
`endif

    // Reset in the middle of the first gap, before any pulse is due.
    load(0);
    ev_count = 6'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_busy", 256'(busy), 256'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 256'(busy), 256'd0);
    check("mid_rst_done", 256'(done), 256'd0);
    check("mid_rst_new", 256'(new_input), 256'd0);
    check("mid_rst_data", input_data, 256'd0);
    check("mid_rst_stall", 256'(stall_cnt), 256'd0);

    ev_count = 6'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("evc0_done", 256'(done), 256'd1);
    check("evc0_busy", 256'(busy), 256'd0);
    for (int i = 0; i < 10; i++) tick();

    run_sched(0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_stimulus_player.md
# event_stimulus_player

Synthesizable, parametrised replacement for hand-written monitor stimulus sequences. It holds a loadable schedule of timestamped input events: each event has a gap, a per-channel mask and per-channel values. It replays the schedule into the monitor's `input_N` / `new_input_N` ports, pulsing each masked channel's new-input flag for exactly one cycle. It sits between a host or loader and the monitor top entity, and respects monitor back-pressure through `ready`.

## Interface
- `NUM_IN`, 4: number of monitor input channels (1..16)
- `DATA_W`, 64: width of each channel value, signed
- `DEPTH`, 32: schedule entries (power of two)
- `GAP_W`, 16: width of the inter-event gap field
- `STALL_W`, 16: width of the stall counter

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global enable; low freezes all state
- `ld_we`  in  1  schedule write strobe
- `ld_addr`  in  $clog2(DEPTH)  entry address
- `ld_gap`  in  GAP_W  gap for entry
- `ld_mask`  in  NUM_IN  channels carrying an event
- `ld_data`  in  NUM_IN*DATA_W  channel values, channel 0 in LSBs
- `ev_count`  in  $clog2(DEPTH)+1  number of entries to play, sampled at start
- `start`  in  1  single-cycle start pulse
- `ready`  in  1  monitor can accept an event this cycle
- `input_data`  out  NUM_IN*DATA_W  channel values to monitor
- `new_input`  out  NUM_IN  per-channel new-event pulses
- `busy`  out  1  schedule playing
- `done`  out  1  schedule finished, sticky
- `stall_cnt`  out  STALL_W  cycles spent waiting on `ready`, saturating

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, `start`=1:
  - If `ev_count`=0, go to DONE.
  - Otherwise latch `ev_count`, set idx=0, cnt=gap[0], clear `stall_cnt`, go to WAIT.
- WAIT, `en`=1:
  - cnt>0: decrement cnt.
  - cnt=0 and `ready`=1: fire entry idx.
    - If idx = ev_count−1, go to DONE.
    - Otherwise idx++, cnt=gap[idx+1].
  - cnt=0 and `ready`=0: hold; `stall_cnt`++ (saturates at all-ones).
- Fire: on the next cycle, `new_input`=mask[idx]. `input_data` carries the entry's values on masked channels and zero on unmasked ones.
- Every non-fire cycle: `new_input`=0 and `input_data`=0.
- DONE: `done`=1. A `start` restarts exactly as from IDLE.
- `start` while in WAIT is ignored.
- `ld_we` is honoured only in IDLE or DONE; ignored while `busy`.
- `en`=0: cnt, idx, state and `stall_cnt` hold; `new_input` is forced 0 on the following cycle.
- `busy` = (state==WAIT).
- Writes and reads to the same entry in the same cycle cannot occur, because loading is blocked while busy.

## Timing
- Reset values: state IDLE; `input_data`=0, `new_input`=0, `busy`=0, `done`=0, `stall_cnt`=0. The schedule memory is not reset.
- Reset mid-playback aborts immediately and returns to IDLE. Loaded entries survive.
- Outputs are registered; there is no combinational path from any input to any output.
- Without stalls or `en` gaps:
  - Event 0's pulse appears gap[0]+2 cycles after the `start` cycle.
  - Event k's pulse appears gap[k]+1 cycles after event k−1's pulse.
- With gap=0 on all entries, pulses occur on consecutive cycles.
- Each stall cycle or `en`-low cycle delays all subsequent events by one cycle.
- `done` rises on the cycle the last event's pulse is driven.

## Configuration
- `EV_PLAYER_LOOP_EN` defined:
  - Adds input `loop` (1 bit).
  - After firing the last entry with `loop`=1, set idx=0, cnt=gap[0] and stay in WAIT. `done` stays 0.
  - `loop`=0 behaves as if the macro were undefined.
- `EV_PLAYER_LOOP_EN` undefined: the `loop` port is absent and the FSM always ends in DONE.

## Structure
- Package `ev_player_pkg`:
  - state enum
  - entry width constant (GAP_W+NUM_IN+NUM_IN*DATA_W)
  - pack/unpack functions for the entry word
- Sub-module `ev_sched_mem`: DEPTH-entry register array with a single write port and an asynchronous read port. It is instantiated once.
- Top module holds the FSM, counters and output registers.

## Test plan
- Load 3 entries (gaps 5/0/2; masks 0001/0011/1000; values 1, {2,3}, 4) and pulse `start` -> pulses at start+7, +8 and +11 cycles with exactly those values, zero elsewhere. `done` rises with the third pulse.
- Same schedule with `ready` low for 4 cycles at the second event -> second and third pulses each shift by 4 cycles, `stall_cnt`=4.
- `en` low for 3 cycles mid-gap -> later events shift by 3 cycles; no pulse is emitted while `en` is low.
- `ev_count`=0 plus `start` -> DONE on the next cycle, no pulses. `ld_we` while busy -> the entry is unchanged on replay.
- Assert `rst` during WAIT -> all outputs 0 on the next cycle. Re-`start` replays the full schedule from entry 0.
- With `EV_PLAYER_LOOP_EN` defined and `loop`=1 on a 2-entry schedule -> the pattern repeats at least 3 times and `done` stays 0. Dropping `loop` -> ends after the current pass.
